look_ahead_route_unit: RTL and testbench

Registered, multi-VC look-ahead routing unit for one router of an X×Y mesh or torus. For each virtual channel's head flit it computes two ports: the output port at this router and the output port at the next router on the path, which is carried forward in the flit. Routing is XY or YX, selected by parameter. A round-robin arbiter time-shares one routing datapath across V request channels, and each channel holds its result in a register until the VC allocator acknowledges it.

---
 rtl/look_ahead_route_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_look_ahead_route_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/look_ahead_route_unit.sv
// look_ahead_route_unit
//   Look-ahead XY/YX router port computation for one mesh/torus router.
//   A round-robin arbiter shares one routing datapath among V head-flit
//   requesters; each channel keeps its result until the VC allocator acks it.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   req_valid   [V]   : head flit waiting for a route, per channel
//   dest_x_in   [V*XW]: packed destination x, channel v at [v*XW +: XW]
//   dest_y_in   [V*YW]: packed destination y, channel v at [v*YW +: YW]
//   req_grant   [V]   : combinational one-hot grant for this cycle
//   result_valid[V]   : result register holds an unacknowledged result
//   cur_port_out[V*PW]: output port at this router
//   lk_port_out [V*PW]: output port at the next router (look-ahead)
//   route_err   [V]   : latched destination was out of range
//   result_ack  [V]   : consumer takes result v
module look_ahead_route_unit #(
    parameter int unsigned V          = 4,
    parameter int unsigned X_NODE_NUM = 4,
    parameter int unsigned Y_NODE_NUM = 4,
    parameter int unsigned SW_X_ADDR  = 2,
    parameter int unsigned SW_Y_ADDR  = 1,
    parameter string       ROUTE_MODE = "XY",
    parameter string       TOPOLOGY   = "MESH",
    parameter int unsigned XW         = (X_NODE_NUM > 1) ? $clog2(X_NODE_NUM) : 1,
    parameter int unsigned YW         = (Y_NODE_NUM > 1) ? $clog2(Y_NODE_NUM) : 1,
    parameter int unsigned PW         = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [V-1:0]    req_valid,
    input  logic [V*XW-1:0] dest_x_in,
    input  logic [V*YW-1:0] dest_y_in,
    output logic [V-1:0]    req_grant,
    output logic [V-1:0]    result_valid,
    output logic [V*PW-1:0] cur_port_out,
    output logic [V*PW-1:0] lk_port_out,
    output logic [V-1:0]    route_err,
    input  logic [V-1:0]    result_ack
);

    localparam int unsigned PTRW     = (V > 1) ? $clog2(V) : 1;
    localparam bit          IS_TORUS = (TOPOLOGY == "TORUS");
    localparam bit          IS_YX    = (ROUTE_MODE == "YX");
    localparam int          XN       = int'(X_NODE_NUM);
    localparam int          YN       = int'(Y_NODE_NUM);
    localparam int          SWX      = int'(SW_X_ADDR);
    localparam int          SWY      = int'(SW_Y_ADDR);

    localparam logic [PW-1:0] P_LOCAL = PW'(0);
    localparam logic [PW-1:0] P_EAST  = PW'(1);
    localparam logic [PW-1:0] P_NORTH = PW'(2);
    localparam logic [PW-1:0] P_WEST  = PW'(3);
    localparam logic [PW-1:0] P_SOUTH = PW'(4);

    // Direction along one dimension: 0 = aligned, +1 = positive, -1 = negative.
    function automatic int dim_dir(input int cur, input int dst, input int n);
        int fwd;
        dim_dir = 0;
        fwd     = 0;
        if (dst != cur) begin
            if (IS_TORUS) begin
                fwd     = (dst >= cur) ? (dst - cur) : (dst + n - cur);
                // equal distance both ways resolves to the positive direction
                dim_dir = (fwd <= n - fwd) ? 1 : -1;
            end else begin
                dim_dir = (dst > cur) ? 1 : -1;
            end
        end
    endfunction

    // Output port taken at router (cx,cy) toward (dx,dy) in dimension order.
    function automatic logic [PW-1:0] port_at(input int cx, input int cy,
                                              input int dx, input int dy);
        int            dir_x;
        int            dir_y;
        logic [PW-1:0] px;
        logic [PW-1:0] py;
        dir_x = dim_dir(cx, dx, XN);
        dir_y = dim_dir(cy, dy, YN);
        px    = (dir_x > 0) ? P_EAST  : ((dir_x < 0) ? P_WEST  : P_LOCAL);
        py    = (dir_y > 0) ? P_SOUTH : ((dir_y < 0) ? P_NORTH : P_LOCAL);
        if (IS_YX) begin
            port_at = (py != P_LOCAL) ? py : px;
        end else begin
            port_at = (px != P_LOCAL) ? px : py;
        end
    endfunction

    // One hop along a dimension; wraps only on a torus (mesh never steps off-grid).
    function automatic int step_coord(input int c, input int delta, input int n);
        step_coord = c + delta;
        if (IS_TORUS) begin
            if (step_coord >= n) begin
                step_coord = 0;
            end else if (step_coord < 0) begin
                step_coord = n - 1;
            end
        end
    endfunction

    logic [V-1:0]    result_valid_q, result_valid_d;
    logic [V*PW-1:0] cur_q, cur_d;
    logic [V*PW-1:0] lk_q, lk_d;
    logic [V-1:0]    err_q, err_d;
    logic [PTRW-1:0] ptr_q, ptr_d;

    logic [V-1:0]    elig_c;
    logic [V-1:0]    grant_c;
    logic            gnt_any_c;
    logic [PTRW-1:0] gnt_idx_c;
    int              cand;

    logic [XW-1:0]   sel_dx;
    logic [YW-1:0]   sel_dy;
    int              dxi, dyi, nx, ny;
    logic [PW-1:0]   rt_cur, rt_lk;
    logic            rt_err;

    // Round-robin arbiter starting at ptr_q over eligible channels.
    always_comb begin
        elig_c    = req_valid & (~result_valid_q | result_ack);
        grant_c   = '0;
        gnt_any_c = 1'b0;
        gnt_idx_c = '0;
        cand      = 0;
        for (int i = 0; i < int'(V); i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= int'(V)) begin
                cand = cand - int'(V);
            end
            if (!gnt_any_c && elig_c[PTRW'(cand)]) begin
                gnt_any_c = 1'b1;
                gnt_idx_c = PTRW'(cand);
            end
        end
        if (reset) begin
            gnt_any_c = 1'b0;
        end
        if (gnt_any_c) begin
            grant_c[gnt_idx_c] = 1'b1;
        end
    end

    // Shared routing datapath for the granted channel.
    always_comb begin
        sel_dx = '0;
        sel_dy = '0;
        for (int v = 0; v < int'(V); v++) begin
            if (gnt_idx_c == PTRW'(v)) begin
                sel_dx = dest_x_in[v*XW +: XW];
                sel_dy = dest_y_in[v*YW +: YW];
            end
        end
        dxi    = int'(sel_dx);
        dyi    = int'(sel_dy);
        rt_err = (dxi >= XN) || (dyi >= YN);
        rt_cur = port_at(SWX, SWY, dxi, dyi);
        nx     = SWX;
        ny     = SWY;
        case (rt_cur)
            P_EAST:  nx = step_coord(SWX,  1, XN);
            P_WEST:  nx = step_coord(SWX, -1, XN);
            P_NORTH: ny = step_coord(SWY, -1, YN);
            P_SOUTH: ny = step_coord(SWY,  1, YN);
            default: ;
        endcase
        rt_lk = (rt_cur == P_LOCAL) ? P_LOCAL : port_at(nx, ny, dxi, dyi);
        if (rt_err) begin
            rt_cur = P_LOCAL;
            rt_lk  = P_LOCAL;
        end
    end

    // Next-state for pointer and per-channel result registers.
    always_comb begin
        result_valid_d = result_valid_q;
        cur_d          = cur_q;
        lk_d           = lk_q;
        err_d          = err_q;
        ptr_d          = ptr_q;
        if (gnt_any_c) begin
            ptr_d = (gnt_idx_c == PTRW'(V - 1)) ? '0 : gnt_idx_c + PTRW'(1);
        end
        for (int v = 0; v < int'(V); v++) begin
            if (grant_c[v]) begin
                result_valid_d[v]    = 1'b1;
                cur_d[v*PW +: PW]    = rt_cur;
                lk_d[v*PW +: PW]     = rt_lk;
                err_d[v]             = rt_err;
            end else if (result_ack[v]) begin
                result_valid_d[v]    = 1'b0;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_valid_q <= '0;
            cur_q          <= '0;
            lk_q           <= '0;
            err_q          <= '0;
            ptr_q          <= '0;
        end else begin
            result_valid_q <= result_valid_d;
            cur_q          <= cur_d;
            lk_q           <= lk_d;
            err_q          <= err_d;
            ptr_q          <= ptr_d;
        end
    end

    assign req_grant    = grant_c;
    assign result_valid = result_valid_q;
    assign cur_port_out = cur_q;
    assign lk_port_out  = lk_q;
    assign route_err    = err_q;

endmodule

// File: tb/tb_look_ahead_route_unit.sv
// Scoreboard bench: several router configurations share one stimulus stream.
module tb_look_ahead_route_unit;

    localparam int V  = 4;
    localparam int XW = 2;
    localparam int YW = 2;
    localparam int PW = 3;
    localparam int NC = 6;

    // cfg: 0 mesh XY (2,1) 4x4, 1 mesh YX (2,1) 4x4, 2 torus XY (2,1) 4x4,
    //      3 torus XY (3,0) 4x4, 4 mesh XY (2,1) 3x4, 5 torus YX (1,1) 3x3
    localparam int CXN  [NC] = '{4, 4, 4, 4, 3, 3};
    localparam int CYN  [NC] = '{4, 4, 4, 4, 4, 3};
    localparam int CSX  [NC] = '{2, 2, 2, 3, 2, 1};
    localparam int CSY  [NC] = '{1, 1, 1, 0, 1, 1};
    localparam int CYX  [NC] = '{0, 1, 0, 0, 0, 1};
    localparam int CTOR [NC] = '{0, 0, 1, 1, 0, 1};

    logic            clk;
    logic            reset;
    logic [V-1:0]    req_valid;
    logic [V*XW-1:0] dest_x_in;
    logic [V*YW-1:0] dest_y_in;
    logic [V-1:0]    result_ack;

    logic [V-1:0]    gnt_w [NC];
    logic [V-1:0]    vld_w [NC];
    logic [V-1:0]    err_w [NC];
    logic [V*PW-1:0] cur_w [NC];
    logic [V*PW-1:0] lk_w  [NC];

    look_ahead_route_unit #(.V(V), .X_NODE_NUM(4), .Y_NODE_NUM(4), .SW_X_ADDR(2), .SW_Y_ADDR(1),
        .ROUTE_MODE("XY"), .TOPOLOGY("MESH"), .XW(XW), .YW(YW), .PW(PW)) u_c0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .dest_x_in(dest_x_in), .dest_y_in(dest_y_in),
        .req_grant(gnt_w[0]), .result_valid(vld_w[0]), .cur_port_out(cur_w[0]), .lk_port_out(lk_w[0]),
        .route_err(err_w[0]), .result_ack(result_ack));
    look_ahead_route_unit #(.V(V), .X_NODE_NUM(4), .Y_NODE_NUM(4), .SW_X_ADDR(2), .SW_Y_ADDR(1),
        .ROUTE_MODE("YX"), .TOPOLOGY("MESH"), .XW(XW), .YW(YW), .PW(PW)) u_c1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .dest_x_in(dest_x_in), .dest_y_in(dest_y_in),
        .req_grant(gnt_w[1]), .result_valid(vld_w[1]), .cur_port_out(cur_w[1]), .lk_port_out(lk_w[1]),
        .route_err(err_w[1]), .result_ack(result_ack));
    look_ahead_route_unit #(.V(V), .X_NODE_NUM(4), .Y_NODE_NUM(4), .SW_X_ADDR(2), .SW_Y_ADDR(1),
        .ROUTE_MODE("XY"), .TOPOLOGY("TORUS"), .XW(XW), .YW(YW), .PW(PW)) u_c2 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .dest_x_in(dest_x_in), .dest_y_in(dest_y_in),
        .req_grant(gnt_w[2]), .result_valid(vld_w[2]), .cur_port_out(cur_w[2]), .lk_port_out(lk_w[2]),
        .route_err(err_w[2]), .result_ack(result_ack));
    look_ahead_route_unit #(.V(V), .X_NODE_NUM(4), .Y_NODE_NUM(4), .SW_X_ADDR(3), .SW_Y_ADDR(0),
        .ROUTE_MODE("XY"), .TOPOLOGY("TORUS"), .XW(XW), .YW(YW), .PW(PW)) u_c3 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .dest_x_in(dest_x_in), .dest_y_in(dest_y_in),
        .req_grant(gnt_w[3]), .result_valid(vld_w[3]), .cur_port_out(cur_w[3]), .lk_port_out(lk_w[3]),
        .route_err(err_w[3]), .result_ack(result_ack));
    look_ahead_route_unit #(.V(V), .X_NODE_NUM(3), .Y_NODE_NUM(4), .SW_X_ADDR(2), .SW_Y_ADDR(1),
        .ROUTE_MODE("XY"), .TOPOLOGY("MESH"), .XW(XW), .YW(YW), .PW(PW)) u_c4 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .dest_x_in(dest_x_in), .dest_y_in(dest_y_in),
        .req_grant(gnt_w[4]), .result_valid(vld_w[4]), .cur_port_out(cur_w[4]), .lk_port_out(lk_w[4]),
        .route_err(err_w[4]), .result_ack(result_ack));
    look_ahead_route_unit #(.V(V), .X_NODE_NUM(3), .Y_NODE_NUM(3), .SW_X_ADDR(1), .SW_Y_ADDR(1),
        .ROUTE_MODE("YX"), .TOPOLOGY("TORUS"), .XW(XW), .YW(YW), .PW(PW)) u_c5 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .dest_x_in(dest_x_in), .dest_y_in(dest_y_in),
        .req_grant(gnt_w[5]), .result_valid(vld_w[5]), .cur_port_out(cur_w[5]), .lk_port_out(lk_w[5]),
        .route_err(err_w[5]), .result_ack(result_ack));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [V-1:0]              vld;
        logic [NC-1:0][V*PW-1:0]   cur;
        logic [NC-1:0][V*PW-1:0]   lk;
        logic [NC-1:0][V-1:0]      err;
    } exp_t;

    exp_t sb_q[$];

    int errors = 0;
    int checks = 0;

    // Reference model state: what every output should hold after the next edge.
    logic [V-1:0]            vld_m;
    logic [NC-1:0][V*PW-1:0] cur_m;
    logic [NC-1:0][V*PW-1:0] lk_m;
    logic [NC-1:0][V-1:0]    err_m;
    int                      ptr_m;

    task automatic chk(input string nm, input int c, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cfg%0d t=%0t actual=%0h required=%0h", nm, c, $time, act, exp);
        end
    endtask

    function automatic int wrapm(input int a, input int n);
        return ((a % n) + n) % n;
    endfunction

    // +1 / -1 / 0 move along one dimension from c toward d.
    function automatic int dimdir(input int c, input int d, input int n, input int tor);
        int f;
        if (c == d) return 0;
        if (tor == 0) return (d > c) ? 1 : -1;
        f = wrapm(d - c, n);
        return (f <= n - f) ? 1 : -1;
    endfunction

    function automatic int port_of(input int cfg, input int cx, input int cy, input int dx, input int dy);
        int mx, my, px, py;
        mx = dimdir(cx, dx, CXN[cfg], CTOR[cfg]);
        my = dimdir(cy, dy, CYN[cfg], CTOR[cfg]);
        px = (mx == 1) ? 1 : ((mx == -1) ? 3 : 0);
        py = (my == 1) ? 4 : ((my == -1) ? 2 : 0);
        if (CYX[cfg] == 1) return (py != 0) ? py : px;
        return (px != 0) ? px : py;
    endfunction

    task automatic ref_route(input int cfg, input int dx, input int dy,
                             output int cp, output int lp, output bit er);
        int nx, ny;
        er = (dx >= CXN[cfg]) || (dy >= CYN[cfg]);
        cp = 0;
        lp = 0;
        if (!er) begin
            cp = port_of(cfg, CSX[cfg], CSY[cfg], dx, dy);
            nx = CSX[cfg];
            ny = CSY[cfg];
            if (cp == 1) nx = nx + 1;
            if (cp == 3) nx = nx - 1;
            if (cp == 2) ny = ny - 1;
            if (cp == 4) ny = ny + 1;
            nx = wrapm(nx, CXN[cfg]);
            ny = wrapm(ny, CYN[cfg]);
            lp = (cp == 0) ? 0 : port_of(cfg, nx, ny, dx, dy);
        end
    endtask

    // Drive one cycle, check the combinational grant, push the expected state.
    task automatic step(input logic [V-1:0] rq, input logic [V*XW-1:0] dx, input logic [V*YW-1:0] dy,
                        input logic [V-1:0] ak, input logic rs, output logic [V-1:0] g);
        exp_t e;
        int   gi, cp, lp;
        bit   er;
        @(negedge clk);
        req_valid  = rq;
        dest_x_in  = dx;
        dest_y_in  = dy;
        result_ack = ak;
        reset      = rs;
        #1;
        g  = '0;
        gi = -1;
        if (!rs) begin
            for (int i = 0; i < V; i++) begin
                int idx;
                idx = (ptr_m + i) % V;
                if (gi < 0 && rq[idx] && (!vld_m[idx] || ak[idx])) gi = idx;
            end
        end
        if (gi >= 0) g[gi] = 1'b1;
        for (int c = 0; c < NC; c++) chk("grant", c, 64'(gnt_w[c]), 64'(g));
        if (rs) begin
            vld_m = '0; cur_m = '0; lk_m = '0; err_m = '0; ptr_m = 0;
        end else begin
            vld_m = vld_m & ~ak;
            if (gi >= 0) begin
                vld_m[gi] = 1'b1;
                ptr_m     = (gi + 1) % V;
                for (int c = 0; c < NC; c++) begin
                    ref_route(c, int'(dx[gi*XW +: XW]), int'(dy[gi*YW +: YW]), cp, lp, er);
                    cur_m[c][gi*PW +: PW] = PW'(cp);
                    lk_m[c][gi*PW +: PW]  = PW'(lp);
                    err_m[c][gi]          = er;
                end
            end
        end
        e.vld = vld_m; e.cur = cur_m; e.lk = lk_m; e.err = err_m;
        sb_q.push_back(e);
    endtask

    // Hold a request set until every member is granted (bounded).
    task automatic hold_until(input logic [V-1:0] mask, input logic [V-1:0] ak,
                              input logic [V*XW-1:0] dx, input logic [V*YW-1:0] dy);
        logic [V-1:0] pend, g;
        int           n;
        pend = mask;
        n    = 0;
        while (pend != '0 && n < 4 * V) begin
            step(pend, dx, dy, ak, 1'b0, g);
            pend = pend & ~g;
            n++;
        end
        checks++;
        if (pend != '0) begin
            errors++;
            $display("FAIL hold_timeout pending=%0h required=0", pend);
        end
    endtask

    // Monitor: compare every registered output once per clock.
    always begin : mon
        exp_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            for (int c = 0; c < NC; c++) begin
                chk("result_valid", c, 64'(vld_w[c]), 64'(e.vld));
                chk("cur_port",     c, 64'(cur_w[c]), 64'(e.cur[c]));
                chk("lk_port",      c, 64'(lk_w[c]),  64'(e.lk[c]));
                chk("route_err",    c, 64'(err_w[c]), 64'(e.err[c]));
            end
        end
    end

    int tx [10] = '{3, 0, 2, 2, 3, 3, 0, 0, 3, 1};
    int ty [10] = '{3, 1, 0, 1, 3, 2, 1, 3, 0, 3};

    initial begin
        logic [V-1:0]    g, pend, ak;
        logic [V*XW-1:0] dxr;
        logic [V*YW-1:0] dyr;
        int              ch;
        bit              rs;

        reset = 1'b1; req_valid = '0; dest_x_in = '0; dest_y_in = '0; result_ack = '0;
        vld_m = '0; cur_m = '0; lk_m = '0; err_m = '0; ptr_m = 0;

        step('0, '0, '0, '0, 1'b1, g);
        step('0, '0, '0, '0, 1'b1, g);

        // Directed destinations, rotating across channels.
        for (int k = 0; k < 10; k++) begin
            ch  = k % V;
            dxr = V*XW'($urandom);
            dyr = V*YW'($urandom);
            dxr[ch*XW +: XW] = XW'(tx[k]);
            dyr[ch*YW +: YW] = YW'(ty[k]);
            step(V'(1) << ch, dxr, dyr, '1, 1'b0, g);
        end

        // All four request together after reset: grants 0,1,2,3, then 3 alone.
        step('0, '0, '0, '0, 1'b1, g);
        hold_until('1, '1, 8'hE4, 8'h1B);
        step(4'b1000, 8'hC0, 8'hC0, '1, 1'b0, g);

        // Back-pressure on channel 1, then ack and re-request together.
        step('0, '0, '0, '1, 1'b0, g);
        step(4'b0010, 8'h0C, 8'h0C, '0, 1'b0, g);
        for (int k = 0; k < 3; k++) step(4'b0010, 8'h00, 8'h04, '0, 1'b0, g);
        step(4'b0010, 8'h00, 8'h04, 4'b0010, 1'b0, g);

        // Fill every result register, then reset while requests are pending.
        step('0, '0, '0, '1, 1'b0, g);
        hold_until('1, '0, 8'h9C, 8'h63);
        step('1, 8'h9C, 8'h63, '0, 1'b1, g);
        step('1, 8'h9C, 8'h63, '0, 1'b0, g);

        // Randomized traffic honoring the hold-until-grant protocol.
        pend = '0; dxr = '0; dyr = '0;
        for (int n = 0; n < 800; n++) begin
            for (int v = 0; v < V; v++) begin
                if (!pend[v] && ($urandom_range(1, 0) == 1)) begin
                    pend[v] = 1'b1;
                    dxr[v*XW +: XW] = XW'($urandom_range(3, 0));
                    dyr[v*YW +: YW] = YW'($urandom_range(3, 0));
                end
            end
            ak = V'($urandom);
            rs = ($urandom_range(99, 0) == 0);
            step(pend, dxr, dyr, ak, rs, g);
            pend = pend & ~g;
            if (rs) pend = '0;
        end

        step('0, '0, '0, '1, 1'b0, g);
        step('0, '0, '0, '0, 1'b0, g);
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d required=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
